routing_dispatch_unit: RTL and testbench
========================================

Name: routing_dispatch_unit

Overview:
- Demultiplexing counterpart of the 4:1 routing unit: takes one valid/ready input stream and steers each word to one of four output channels y0..y3, or to all four at once (broadcast).
- Each output channel has its own DEPTH-entry FIFO, so a stalled consumer does not block traffic to the other channels.
- Sits between an upstream producer and four downstream consumers in the HP-AU datapath.

Parameters:
- WIDTH, 4, data width of the input word and of every output channel.
- DEPTH, 2, entries per channel FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to dispatch.
- in_dest  input  2  destination channel: 0 to 3 selects y0 to y3.
- in_bcast  input  1  1 sends the word to all four channels; in_dest is ignored.
- in_valid  input  1  in_data, in_dest and in_bcast are valid.
- in_ready  output  1  unit can accept the presented word.
- y0, y1, y2, y3  output  WIDTH each  head word of channel 0 to 3 FIFO.
- out_valid  output  4  bit n high means yn holds a valid word.
- out_ready  input  4  bit n high means consumer n takes yn this cycle.
- accept_cnt  output  CNT_W  number of input words accepted (a broadcast counts once).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO counts and pointers go to 0 and all storage is cleared.
  - out_valid=4'b0000, y0..y3=0, accept_cnt=0.
  - Words held at reset are discarded, including in the middle of a transfer.
  - in_ready is 0 while rst_n is low.
- full[n] = (count[n]==DEPTH), taken from registered state only.
- in_ready:
  - When in_bcast=1: in_ready = no channel full.
  - When in_bcast=0: in_ready = ~full[in_dest].
  - in_ready is combinational on in_dest, in_bcast and registered state. It never depends on in_valid or on out_ready.
- Accept: in_valid & in_ready at a rising edge.
  - The word is written to the tail of the destination FIFO, or to all four FIFOs on a broadcast.
  - accept_cnt increments by 1 and wraps from all-ones to 0.
- Pop: out_valid[n] & out_ready[n] at a rising edge removes the head of FIFO n. out_ready[n] while out_valid[n]=0 has no effect.
- Output view:
  - out_valid[n] = (count[n]!=0).
  - yn = the registered head entry of FIFO n, with no combinational path from in_data.
  - yn holds its last value when the FIFO is empty.
- Latency: a word accepted at edge k into an empty FIFO is visible on yn with out_valid[n]=1 right after edge k (1 cycle).
- Simultaneous push and pop on the same channel:
  - Not full: both happen and the count is unchanged.
  - Full: in_ready was already 0, so only the pop occurs. Space freed by a pop can be used from the next cycle (no same-cycle pass-through).
- Broadcast with one channel full stalls the whole input. There is no partial write.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee between different channels.
- Counters and pointers wrap modulo DEPTH; count ranges from 0 to DEPTH inclusive.
- The producer may change in_dest while in_valid=1 and in_ready=0; the unit evaluates whatever is presented each cycle.

Test Plan:
- Reset then idle: release rst_n with in_valid=0. Required: out_valid=0000, y0..y3=0, accept_cnt=0, in_ready=1 for any dest.
- Directed routing (WIDTH=4, out_ready=1111): send A to dest 0, B to 1, C to 2, D to 3 on consecutive cycles. Required: y0=A, y1=B, y2=C, y3=D, each with out_valid high for exactly one cycle, 1 cycle after its accept; accept_cnt=4.
- Backpressure (out_ready[2]=0, DEPTH=2): send 1, 2, 3 to dest 2. Required: 1 and 2 accepted, in_ready=0 on the third. Then raise out_ready[2]: y2 shows 1 then 2, word 3 is accepted the cycle after the first pop, and y2 then shows 3.
- Non-blocking (channel 2 full as above): send 5 to dest 1. Required: in_ready=1, accepted, y1=5 while channel 2 stays stalled.
- Broadcast: in_bcast=1, data=F, with channel 3 full. Required: in_ready=0 and no FIFO changes. After one pop on channel 3: accepted, all four channels get F, accept_cnt increments by exactly 1.
- Reset mid-operation: fill two channels, pulse rst_n low between clock edges. Required: out_valid=0000 and y outputs=0 immediately (asynchronous), accept_cnt=0; further pops produce no data. With CNT_W=4, 16 accepts wrap accept_cnt back to 0.

Source files
------------

// File: rtl/routing_dispatch_unit.sv
// One-to-four stream dispatcher with a private FIFO per output channel.
// Words go to channel in_dest, or to all four channels when in_bcast is set.
module routing_dispatch_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] accept_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [4][DEPTH];
  logic [PW-1:0]    wptr_r [4];
  logic [PW-1:0]    rptr_r [4];
  logic [CW-1:0]    count_r [4];
  logic [WIDTH-1:0] head_r [4];
  logic [3:0]       valid_r;
  logic [CNT_W-1:0] accept_cnt_r;

  logic [3:0]       full_s;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;
  logic             ready_s;
  logic             accept_s;
  logic [CW-1:0]    count_nxt_s [4];
  logic [PW-1:0]    rptr_nxt_s [4];
  logic [WIDTH-1:0] head_nxt_s [4];

  // Input handshake: a broadcast needs room in every channel, so it never writes partially.
  always_comb begin
    ready_s = 1'b0;
    for (int n = 0; n < 4; n++) begin
      full_s[n] = (count_r[n] == CW'(DEPTH));
    end
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (in_bcast) begin
      ready_s = ~(|full_s);
    end else begin
      ready_s = ~full_s[in_dest];
    end
    accept_s = in_valid & ready_s;
    for (int n = 0; n < 4; n++) begin
      push_s[n] = accept_s & (in_bcast | (in_dest == 2'(n)));
    end
    pop_s = valid_r & out_ready;
  end

  // Next count, read pointer and head word per channel; the head is pre-computed
  // so yn comes straight from a register and holds its value once the FIFO drains.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      count_nxt_s[n] = count_r[n];
      rptr_nxt_s[n]  = rptr_r[n];
      head_nxt_s[n]  = head_r[n];
      case ({push_s[n], pop_s[n]})
        2'b10:   count_nxt_s[n] = count_r[n] + CW'(1);
        2'b01:   count_nxt_s[n] = count_r[n] - CW'(1);
        default: count_nxt_s[n] = count_r[n];
      endcase
      if (pop_s[n]) begin
        rptr_nxt_s[n] = rptr_r[n] + PW'(1);
      end else begin
        rptr_nxt_s[n] = rptr_r[n];
      end
      if (count_nxt_s[n] == CW'(0)) begin
        head_nxt_s[n] = head_r[n];
      end else if (push_s[n] && (wptr_r[n] == rptr_nxt_s[n])) begin
        head_nxt_s[n] = in_data;
      end else begin
        head_nxt_s[n] = mem_r[n][rptr_nxt_s[n]];
      end
    end
  end

  // FIFO storage, pointers, head/valid registers and the accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[n][d] <= '0;
        end
        wptr_r[n]  <= '0;
        rptr_r[n]  <= '0;
        count_r[n] <= '0;
        head_r[n]  <= '0;
      end
      valid_r      <= 4'b0000;
      accept_cnt_r <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push_s[n]) begin
          mem_r[n][wptr_r[n]] <= in_data;
          wptr_r[n]           <= wptr_r[n] + PW'(1);
        end
        rptr_r[n]  <= rptr_nxt_s[n];
        count_r[n] <= count_nxt_s[n];
        head_r[n]  <= head_nxt_s[n];
        valid_r[n] <= (count_nxt_s[n] != CW'(0));
      end
      if (accept_s) begin
        accept_cnt_r <= accept_cnt_r + CNT_W'(1);
      end
    end
  end

  assign in_ready   = ready_s;
  assign out_valid  = valid_r;
  assign y0         = head_r[0];
  assign y1         = head_r[1];
  assign y2         = head_r[2];
  assign y3         = head_r[3];
  assign accept_cnt = accept_cnt_r;

endmodule

// File: tb/tb_routing_dispatch_unit.sv
// Directed bench for routing_dispatch_unit (WIDTH=4, DEPTH=2, CNT_W=4 so the
// accept counter wrap can be exercised in 16 accepts).
module tb_routing_dispatch_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic [1:0] in_dest;
  logic       in_bcast;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] accept_cnt;
  logic [3:0] yv [4];
  logic [3:0] exp_cnt;
  int         n_cmp;
  int         n_fail;

  routing_dispatch_unit #(.WIDTH(4), .DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid),
    .out_ready(out_ready), .accept_cnt(accept_cnt)
  );

  assign yv[0] = y0;
  assign yv[1] = y1;
  assign yv[2] = y2;
  assign yv[3] = y3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bcast = 1'b0; in_dest = 2'd0;
    in_data = 4'h0; out_ready = 4'b0000;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    step(); step();
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got=%b want=0000", out_valid); end
    n_cmp++; if ({y0, y1, y2, y3} !== 16'h0000) begin n_fail++; $display("FAIL reset_y got=%h want=0000", {y0, y1, y2, y3}); end
    n_cmp++; if (accept_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d want=0", accept_cnt); end
    for (int d = 0; d < 4; d++) begin
      in_dest = 2'(d);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_dest%0d got=%b want=1", d, in_ready); end
    end
    in_bcast = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_bcast got=%b want=1", in_ready); end
    in_bcast = 1'b0;
    step();
  endtask

  task automatic test_routing();
    logic [3:0] words [4];
    words[0] = 4'hA; words[1] = 4'hB; words[2] = 4'hC; words[3] = 4'hD;
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dest = 2'(i); in_data = words[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route_ready%0d got=%b want=1", i, in_ready); end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (out_valid !== 4'(1 << i)) begin n_fail++; $display("FAIL route_valid%0d got=%b want=%b", i, out_valid, 4'(1 << i)); end
      n_cmp++; if (yv[i] !== words[i]) begin n_fail++; $display("FAIL route_y%0d got=%h want=%h", i, yv[i], words[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL route_drain got=%b want=0000", out_valid); end
    n_cmp++; if (accept_cnt !== exp_cnt) begin n_fail++; $display("FAIL route_cnt got=%0d want=%0d", accept_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    in_valid = 1'b1; in_bcast = 1'b0; in_dest = 2'd2; in_data = 4'h1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if ((out_valid[2] !== 1'b1) || (y2 !== 4'h1)) begin n_fail++; $display("FAIL bp_first got v=%b y2=%h want v=1 y2=1", out_valid[2], y2); end
    in_data = 4'h2;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready2 got=%b want=1", in_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    in_data = 4'h3;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
    step();
    n_cmp++; if (y2 !== 4'h1) begin n_fail++; $display("FAIL bp_hold_y2 got=%h want=1", y2); end
    n_cmp++; if (accept_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt got=%0d want=%0d", accept_cnt, exp_cnt); end
  endtask

  task automatic test_nonblocking();
    in_dest = 2'd1; in_data = 4'h5;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nb_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    n_cmp++; if ((out_valid !== 4'b0110) || (y1 !== 4'h5) || (y2 !== 4'h1)) begin
      n_fail++; $display("FAIL nb_view got v=%b y1=%h y2=%h want v=0110 y1=5 y2=1", out_valid, y1, y2);
    end
  endtask

  task automatic test_drain();
    in_dest = 2'd2; in_data = 4'h3;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_still_full got=%b want=0", in_ready); end
    out_ready = 4'b1111;
    step();
    n_cmp++; if ((y2 !== 4'h2) || (in_ready !== 1'b1)) begin n_fail++; $display("FAIL drain_pop1 got y2=%h rdy=%b want y2=2 rdy=1", y2, in_ready); end
    step();
    exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b0;
    n_cmp++; if ((y2 !== 4'h3) || (out_valid[2] !== 1'b1)) begin n_fail++; $display("FAIL drain_word3 got y2=%h v=%b want y2=3 v=1", y2, out_valid[2]); end
    step();
    n_cmp++; if ((out_valid !== 4'b0000) || (y2 !== 4'h3)) begin n_fail++; $display("FAIL drain_empty got v=%b y2=%h want v=0000 y2=3", out_valid, y2); end
    n_cmp++; if (accept_cnt !== exp_cnt) begin n_fail++; $display("FAIL drain_cnt got=%0d want=%0d", accept_cnt, exp_cnt); end
  endtask

  task automatic test_broadcast();
    out_ready = 4'b0111;
    in_valid = 1'b1; in_bcast = 1'b0; in_dest = 2'd3; in_data = 4'h7;
    step();
    in_data = 4'h8;
    step();
    exp_cnt = exp_cnt + 4'd2;
    in_bcast = 1'b1; in_data = 4'hF; in_dest = 2'd0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bc_stall_ready got=%b want=0", in_ready); end
    step();
    n_cmp++; if ((out_valid !== 4'b1000) || (accept_cnt !== exp_cnt)) begin
      n_fail++; $display("FAIL bc_no_write got v=%b cnt=%0d want v=1000 cnt=%0d", out_valid, accept_cnt, exp_cnt);
    end
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0111;
    n_cmp++; if ((y3 !== 4'h8) || (in_ready !== 1'b1)) begin n_fail++; $display("FAIL bc_pop3 got y3=%h rdy=%b want y3=8 rdy=1", y3, in_ready); end
    step();
    exp_cnt = exp_cnt + 4'd1;
    in_valid = 1'b0; in_bcast = 1'b0;
    n_cmp++; if ((out_valid !== 4'b1111) || ({y0, y1, y2} !== 12'hFFF) || (y3 !== 4'h8)) begin
      n_fail++; $display("FAIL bc_all got v=%b y=%h%h%h%h want v=1111 y=FFF8", out_valid, y0, y1, y2, y3);
    end
    n_cmp++; if (accept_cnt !== exp_cnt) begin n_fail++; $display("FAIL bc_cnt got=%0d want=%0d", accept_cnt, exp_cnt); end
    out_ready = 4'b1111;
    step();
    n_cmp++; if ((out_valid !== 4'b1000) || (y3 !== 4'hF)) begin n_fail++; $display("FAIL bc_ch3_f got v=%b y3=%h want v=1000 y3=F", out_valid, y3); end
    step();
    n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bc_drain got=%b want=0000", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_bcast = 1'b0; in_dest = 2'd0; in_data = 4'h1;
    step();
    in_data = 4'h2;
    step();
    in_dest = 2'd1; in_data = 4'h3;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_cnt = 4'd0;
    n_cmp++; if ((out_valid !== 4'b0000) || ({y0, y1, y2, y3} !== 16'h0000) || (accept_cnt !== 4'd0)) begin
      n_fail++; $display("FAIL mid_reset got v=%b y=%h cnt=%0d want v=0000 y=0000 cnt=0", out_valid, {y0, y1, y2, y3}, accept_cnt);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    n_cmp++; if ((out_valid !== 4'b0000) || ({y0, y1, y2, y3} !== 16'h0000)) begin
      n_fail++; $display("FAIL mid_after_pop got v=%b y=%h want v=0000 y=0000", out_valid, {y0, y1, y2, y3});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b1111;
    in_bcast = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_dest = 2'(i % 4); in_data = 4'(i);
      step();
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++; if (yv[i % 4] !== 4'(i)) begin n_fail++; $display("FAIL b2b_y%0d got=%h want=%h", i % 4, yv[i % 4], 4'(i)); end
      if (i == 14) begin
        n_cmp++; if (accept_cnt !== 4'd15) begin n_fail++; $display("FAIL b2b_cnt15 got=%0d want=15", accept_cnt); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (accept_cnt !== 4'd0) begin n_fail++; $display("FAIL b2b_wrap got=%0d want=0", accept_cnt); end
    n_cmp++; if (accept_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got=%0d want=%0d", accept_cnt, exp_cnt); end
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_cnt = 4'd0;
    test_reset();
    test_routing();
    test_backpressure();
    test_nonblocking();
    test_drain();
    test_broadcast();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
